// File: rtl/dm_pkg.sv
// dm_pkg: shared definitions for the wait-state data memory.
//   - size codes for byte / half / word accesses
//   - FSM state type
//   - lane_mask(): byte-enable for a (size, lane) pair
//   - misaligned(): alignment fault check for a (size, lane) pair
package dm_pkg;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;   // 2'b11 behaves as word too

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DONE = 2'd2
    } dm_state_t;

    function automatic logic [3:0] lane_mask(input logic [1:0] size, input logic [1:0] lane);
        logic [3:0] m;
        case (size)
            SZ_BYTE: m = 4'b0001 << lane;
            SZ_HALF: m = lane[1] ? 4'b1100 : 4'b0011;
            default: m = 4'b1111;
        endcase
        return m;
    endfunction

    function automatic logic misaligned(input logic [1:0] size, input logic [1:0] lane);
        logic f;
        case (size)
            SZ_BYTE: f = 1'b0;
            SZ_HALF: f = lane[0];
            default: f = (lane != 2'b00);
        endcase
        return f;
    endfunction

endpackage

// File: rtl/dm_lane_align.sv
// dm_lane_align: combinational lane steering between the 32-bit memory word
// and the right-aligned CPU data.
//   i_size, i_lane  access size and byte lane (addr[1:0])
//   i_sext          1 = sign-extend loads, 0 = zero-extend
//   i_wdata         right-aligned store data
//   i_rword         current memory word at the addressed index
//   o_wdata         store data replicated into every candidate lane
//   o_be            byte enables for the store
//   o_rdata         extracted and extended load value
module dm_lane_align
    import dm_pkg::*;
(
    input  logic [1:0]  i_size,
    input  logic [1:0]  i_lane,
    input  logic        i_sext,
    input  logic [31:0] i_wdata,
    input  logic [31:0] i_rword,
    output logic [31:0] o_wdata,
    output logic [3:0]  o_be,
    output logic [31:0] o_rdata
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    assign o_be   = lane_mask(i_size, i_lane);
    assign w_byte = i_rword[{i_lane, 3'b000} +: 8];
    assign w_half = i_lane[1] ? i_rword[31:16] : i_rword[15:0];

    // Replicating the data lets the byte enables alone pick the lanes.
    always_comb begin
        o_wdata = i_wdata;
        o_rdata = i_rword;
        case (i_size)
            SZ_BYTE: begin
                o_wdata = {4{i_wdata[7:0]}};
                o_rdata = {{24{i_sext & w_byte[7]}}, w_byte};
            end
            SZ_HALF: begin
                o_wdata = {2{i_wdata[15:0]}};
                o_rdata = {{16{i_sext & w_half[15]}}, w_half};
            end
            default: begin
                o_wdata = i_wdata;
                o_rdata = i_rword;
            end
        endcase
    end

endmodule

// File: rtl/dm_wait.sv
// dm_wait: data memory with byte/half/word access, LATENCY wait states and
// a req/ready handshake.
//   clk, rstn            clock, async active-low reset
//   req, we, size, sext  request; held stable until ready
//   addr, wdata          byte address, right-aligned store data
//   rdata                load result, valid with ready on loads
//   ready                one-cycle completion pulse
//   stall                req & ~ready, for the pipeline hazard unit
//   misalign             fault pulse together with ready
//   dbg_addr, dbg_data   combinational read-only view of committed memory
module dm_wait
    import dm_pkg::*;
#(
    parameter int ADDR_W  = 7,
    parameter int LATENCY = 1
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              req,
    input  logic              we,
    input  logic [1:0]        size,
    input  logic              sext,
    input  logic [31:0]       addr,
    input  logic [31:0]       wdata,
    output logic [31:0]       rdata,
    output logic              ready,
    output logic              stall,
    output logic              misalign,
    input  logic [ADDR_W-1:0] dbg_addr,
    output logic [31:0]       dbg_data
);

    localparam int         DEPTH    = 2 ** ADDR_W;
    localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

    dm_state_t         r_state;
    logic [3:0]        r_cnt;
    logic [ADDR_W-1:0] r_widx;
    logic [1:0]        r_lane;
    logic              r_we;
    logic [1:0]        r_size;
    logic              r_sext;
    logic [31:0]       r_wdata;
    logic              r_ready;
    logic              r_misalign;
    logic [31:0]       r_rdata;
    logic [31:0]       r_mem [DEPTH];

    logic [31:0] w_rword;
    logic [31:0] w_wrep;
    logic [3:0]  w_be;
    logic [31:0] w_rext;
    logic        w_fault;
    logic        w_unused;

    // Address bits above the array are ignored, so accesses wrap.
    assign w_unused = ^addr[31:ADDR_W+2];

    assign w_rword = r_mem[r_widx];
    assign w_fault = misaligned(r_size, r_lane);

    dm_lane_align u_align (
        .i_size  (r_size),
        .i_lane  (r_lane),
        .i_sext  (r_sext),
        .i_wdata (r_wdata),
        .i_rword (w_rword),
        .o_wdata (w_wrep),
        .o_be    (w_be),
        .o_rdata (w_rext)
    );

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state    <= IDLE;
            r_cnt      <= 4'd0;
            r_widx     <= '0;
            r_lane     <= 2'b00;
            r_we       <= 1'b0;
            r_size     <= SZ_BYTE;
            r_sext     <= 1'b0;
            r_wdata    <= 32'd0;
            r_ready    <= 1'b0;
            r_misalign <= 1'b0;
            r_rdata    <= 32'd0;
        end else begin
            case (r_state)
                IDLE: begin
                    r_ready    <= 1'b0;
                    r_misalign <= 1'b0;
                    r_rdata    <= 32'd0;
                    if (req) begin
                        r_state <= WAIT;
                        r_cnt   <= CNT_INIT;
                        r_widx  <= addr[ADDR_W+1:2];
                        r_lane  <= addr[1:0];
                        r_we    <= we;
                        r_size  <= size;
                        r_sext  <= sext;
                        r_wdata <= wdata;
                    end
                end
                WAIT: begin
                    if (r_cnt != 4'd0) begin
                        r_cnt <= r_cnt - 4'd1;
                    end else begin
                        // Outputs are registered here so they are valid throughout DONE.
                        r_state    <= DONE;
                        r_ready    <= 1'b1;
                        r_misalign <= w_fault;
                        r_rdata    <= (!r_we && !w_fault) ? w_rext : 32'd0;
                    end
                end
                DONE: begin
                    r_state    <= IDLE;
                    r_ready    <= 1'b0;
                    r_misalign <= 1'b0;
                    r_rdata    <= 32'd0;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    // Store commits on the edge that leaves DONE; reset forces IDLE, which
    // abandons any pending write.
    always_ff @(posedge clk) begin
        if (r_state == DONE && r_we && !w_fault) begin
            for (int b = 0; b < 4; b++) begin
                if (w_be[b]) r_mem[r_widx][b*8 +: 8] <= w_wrep[b*8 +: 8];
            end
        end
    end

    assign rdata    = r_rdata;
    assign ready    = r_ready;
    assign misalign = r_misalign;
    assign stall    = req & ~r_ready;
    assign dbg_data = r_mem[dbg_addr];

endmodule

// File: tb/tb_dm_wait.sv
module tb_dm_wait;

    typedef struct {
        logic [31:0] rd;
        bit          chk;
        bit          mis;
    } exp_t;

    logic        clk = 1'b0;
    logic        a_rstn, b_rstn;
    logic        a_req, a_we, a_sext, b_req, b_we, b_sext;
    logic [1:0]  a_size, b_size;
    logic [31:0] a_addr, a_wdata, b_addr, b_wdata;
    logic [31:0] a_rdata, b_rdata, a_dbg_data, b_dbg_data;
    logic        a_ready, a_stall, a_mis, b_ready, b_stall, b_mis;
    logic [6:0]  a_dbg_addr, b_dbg_addr;

    int   total = 0;
    int   bad   = 0;
    int   cyc_cnt = 0;
    exp_t q0[$];
    exp_t q1[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

    dm_wait #(.ADDR_W(7), .LATENCY(1)) u_a (
        .clk(clk), .rstn(a_rstn), .req(a_req), .we(a_we), .size(a_size), .sext(a_sext),
        .addr(a_addr), .wdata(a_wdata), .rdata(a_rdata), .ready(a_ready), .stall(a_stall),
        .misalign(a_mis), .dbg_addr(a_dbg_addr), .dbg_data(a_dbg_data)
    );

    dm_wait #(.ADDR_W(7), .LATENCY(4)) u_b (
        .clk(clk), .rstn(b_rstn), .req(b_req), .we(b_we), .size(b_size), .sext(b_sext),
        .addr(b_addr), .wdata(b_wdata), .rdata(b_rdata), .ready(b_ready), .stall(b_stall),
        .misalign(b_mis), .dbg_addr(b_dbg_addr), .dbg_data(b_dbg_data)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Monitors: pop one expectation per ready pulse.
    always @(negedge clk) begin
        if (a_ready === 1'b1) begin
            if (q0.size() == 0) begin
                total++; bad++;
                $display("FAIL a_unexpected_ready: got ready with empty queue");
            end else begin
                exp_t e;
                e = q0.pop_front();
                check("a_misalign", {31'd0, a_mis}, {31'd0, e.mis});
                if (e.chk) check("a_rdata", a_rdata, e.rd);
            end
        end
    end

    always @(negedge clk) begin
        if (b_ready === 1'b1) begin
            if (q1.size() == 0) begin
                total++; bad++;
                $display("FAIL b_unexpected_ready: got ready with empty queue");
            end else begin
                exp_t e;
                e = q1.pop_front();
                check("b_misalign", {31'd0, b_mis}, {31'd0, e.mis});
                if (e.chk) check("b_rdata", b_rdata, e.rd);
            end
        end
    end

    function automatic logic rdy(input bit b);
        return b ? b_ready : a_ready;
    endfunction

    function automatic logic stl(input bit b);
        return b ? b_stall : a_stall;
    endfunction

    task automatic drive(input bit b, input logic r, input logic w, input logic [1:0] sz,
                         input logic sx, input logic [31:0] ad, input logic [31:0] wd);
        if (b) begin
            b_req = r; b_we = w; b_size = sz; b_sext = sx; b_addr = ad; b_wdata = wd;
        end else begin
            a_req = r; a_we = w; a_size = sz; a_sext = sx; a_addr = ad; a_wdata = wd;
        end
    endtask

    // Waits for ready; cyc = cycles before the ready cycle, st = stall-high cycles among them.
    task automatic wait_ready(input bit b, output int cyc, output int st, output bit ok);
        cyc = 0; st = 0; ok = 0;
        for (int k = 0; k < 50; k++) begin
            @(negedge clk);
            if (rdy(b) === 1'b1) begin
                ok = 1;
                break;
            end
            if (stl(b) === 1'b1) st++;
            cyc++;
        end
        if (!ok) begin
            total++; bad++;
            $display("FAIL %s_timeout: no ready within 50 cycles", b ? "b" : "a");
        end
    endtask

    task automatic access(input bit b, input logic w, input logic [1:0] sz, input logic sx,
                          input logic [31:0] ad, input logic [31:0] wd,
                          input logic [31:0] erd, input bit chk, input bit emis);
        exp_t e;
        int cyc, st, lat;
        bit ok;
        lat = b ? 4 : 1;
        e.rd = erd; e.chk = chk; e.mis = emis;
        if (b) q1.push_back(e); else q0.push_back(e);
        @(posedge clk); #1;
        drive(b, 1'b1, w, sz, sx, ad, wd);
        wait_ready(b, cyc, st, ok);
        if (ok) begin
            check(b ? "b_latency" : "a_latency", cyc, lat + 1);
            check(b ? "b_stall_cycles" : "a_stall_cycles", st, lat + 1);
            check(b ? "b_stall_at_ready" : "a_stall_at_ready", {31'd0, stl(b)}, 32'd0);
        end
        @(posedge clk); #1;
        drive(b, 1'b0, 1'b0, 2'b00, 1'b0, 32'd0, 32'd0);
    endtask

    initial begin
        int t1, t2, cyc, st;
        bit ok1, ok2;
        a_rstn = 1'b0; b_rstn = 1'b0;
        drive(1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 32'd0, 32'd0);
        drive(1'b1, 1'b0, 1'b0, 2'b00, 1'b0, 32'd0, 32'd0);
        a_dbg_addr = 7'd4; b_dbg_addr = 7'd8;
        #23;
        check("rst_ready", {31'd0, a_ready}, 32'd0);
        check("rst_misalign", {31'd0, a_mis}, 32'd0);
        check("rst_rdata", a_rdata, 32'd0);
        check("rst_stall", {31'd0, a_stall}, 32'd0);
        check("rst_b_ready", {31'd0, b_ready}, 32'd0);
        @(negedge clk);
        a_rstn = 1'b1; b_rstn = 1'b1;

        // LATENCY=1 functional sequence
        access(0, 1, 2'b10, 0, 32'h10, 32'hDEADBEEF, 32'd0, 0, 0);
        check("dbg_sw", a_dbg_data, 32'hDEADBEEF);
        access(0, 0, 2'b10, 0, 32'h10, 32'd0, 32'hDEADBEEF, 1, 0);
        access(0, 1, 2'b00, 0, 32'h11, 32'h12345680, 32'd0, 0, 0);
        check("dbg_sb", a_dbg_data, 32'hDEAD80EF);
        access(0, 0, 2'b00, 1, 32'h11, 32'd0, 32'hFFFFFF80, 1, 0);
        access(0, 0, 2'b00, 0, 32'h11, 32'd0, 32'h00000080, 1, 0);
        access(0, 1, 2'b01, 0, 32'h12, 32'h00001234, 32'd0, 0, 0);
        check("dbg_sh", a_dbg_data, 32'h123480EF);
        access(0, 0, 2'b01, 1, 32'h12, 32'd0, 32'h00001234, 1, 0);
        access(0, 0, 2'b01, 1, 32'h10, 32'd0, 32'hFFFF80EF, 1, 0);
        access(0, 0, 2'b01, 0, 32'h10, 32'd0, 32'h000080EF, 1, 0);
        access(0, 0, 2'b00, 0, 32'h13, 32'd0, 32'h00000012, 1, 0);
        access(0, 0, 2'b11, 0, 32'h10, 32'd0, 32'h123480EF, 1, 0);
        // misaligned accesses
        access(0, 1, 2'b10, 0, 32'h13, 32'h11111111, 32'd0, 1, 1);
        check("dbg_misalign_sw", a_dbg_data, 32'h123480EF);
        access(0, 1, 2'b01, 0, 32'h11, 32'h00002222, 32'd0, 1, 1);
        check("dbg_misalign_sh", a_dbg_data, 32'h123480EF);
        access(0, 0, 2'b10, 0, 32'h12, 32'd0, 32'd0, 1, 1);
        // address wrap: 0x210 aliases 0x10
        access(0, 0, 2'b10, 0, 32'h210, 32'd0, 32'h123480EF, 1, 0);

        // LATENCY=4: store then back-to-back loads with req held high
        access(1, 1, 2'b10, 0, 32'h20, 32'h55555555, 32'd0, 0, 0);
        check("b_dbg_sw", b_dbg_data, 32'h55555555);
        q1.push_back('{rd: 32'h55555555, chk: 1, mis: 0});
        q1.push_back('{rd: 32'h00000055, chk: 1, mis: 0});
        @(posedge clk); #1;
        drive(1, 1'b1, 1'b0, 2'b10, 1'b0, 32'h20, 32'd0);
        wait_ready(1, cyc, st, ok1);
        t1 = cyc_cnt;
        @(posedge clk); #1;
        drive(1, 1'b1, 1'b0, 2'b00, 1'b0, 32'h21, 32'd0);
        wait_ready(1, cyc, st, ok2);
        t2 = cyc_cnt;
        if (ok1 && ok2) check("b2b_gap_cycles", t2 - t1 - 1, 5);
        @(posedge clk); #1;
        drive(1, 1'b0, 1'b0, 2'b00, 1'b0, 32'd0, 32'd0);

        // reset in the middle of a store's WAIT phase
        @(posedge clk); #1;
        drive(1, 1'b1, 1'b1, 2'b10, 1'b0, 32'h20, 32'hCAFEF00D);
        repeat (3) @(negedge clk);
        b_rstn = 1'b0;
        #1;
        check("midrst_ready", {31'd0, b_ready}, 32'd0);
        check("midrst_misalign", {31'd0, b_mis}, 32'd0);
        check("midrst_rdata", b_rdata, 32'd0);
        drive(1, 1'b0, 1'b0, 2'b00, 1'b0, 32'd0, 32'd0);
        repeat (2) @(negedge clk);
        b_rstn = 1'b1;
        check("midrst_no_write", b_dbg_data, 32'h55555555);
        access(1, 0, 2'b10, 0, 32'h20, 32'd0, 32'h55555555, 1, 0);
        repeat (3) @(negedge clk);
        check("b_dbg_after", b_dbg_data, 32'h55555555);

        check("a_queue_empty", q0.size(), 0);
        check("b_queue_empty", q1.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
